// File: rtl/vec_dot_accumulator.sv
// Reduction half of the vector MAC: sums a programmed number of signed 8-bit
// products into a saturating accumulator and hands the result downstream.
module vec_dot_accumulator #(
    parameter int VLEN  = 8,
    parameter int ACC_W = 10,
    parameter int LEN_W = $clog2(VLEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [7:0]       in_prod,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] VLEN_L  = LEN_W'(VLEN);

    // Returns {clamped, result}; one guard bit is enough since |prod| < |acc range|.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [7:0]       prod);
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W-7){prod[7]}}, prod};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                sat_add = {1'b1, ACC_MIN};
            end else begin
                sat_add = {1'b1, ACC_MAX};
            end
        end else begin
            sat_add = {1'b0, sum[ACC_W-1:0]};
        end
    endfunction

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [ACC_W:0]     add_res_s;

    // Next-state, datapath and counter update.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sat_d     = sat_q;
        add_res_s = sat_add(acc_q, in_prod);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = (len > VLEN_L) ? VLEN_L : len;
                    cnt_d = {LEN_W{1'b0}};
                    acc_d = {ACC_W{1'b0}};
                    sat_d = 1'b0;
                    if (len == {LEN_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                // in_ready is constant-high here, so in_valid alone marks a beat
                if (in_valid) begin
                    acc_d = add_res_s[ACC_W-1:0];
                    sat_d = sat_q | add_res_s[ACC_W];
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= {LEN_W{1'b0}};
            cnt_q   <= {LEN_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;

endmodule

// File: doc/vec_dot_accumulator.md
# vec_dot_accumulator

Downstream consumer of the 8-bit truncated multiplier stage in the vector datapath. Accepts a stream of signed 8-bit truncated products, one per element, over a valid/ready handshake. Sums a programmed number of elements into a signed saturating accumulator and presents the dot-product result on a second valid/ready handshake. It forms the reduction half of the vector multiply-accumulate unit.

## Interface
- `VLEN`, 8, maximum elements per reduction (≥1)
- `ACC_W`, 10, accumulator / result width in bits, signed (≥8)
- `LEN_W`, $clog2(VLEN+1), width of `len`
- One clock; reset is asynchronous and active-high.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous active-high reset
- `start`  input  1  begin reduction; sampled only in IDLE
- `len`  input  LEN_W  element count, sampled with `start`
- `in_valid`  input  1  product beat valid
- `in_prod`  input  8  signed truncated product
- `in_ready`  output  1  accumulator accepting beats
- `out_valid`  output  1  result valid
- `out_ready`  input  1  downstream accepts result
- `out_sum`  output  ACC_W  signed accumulated result
- `out_sat`  output  1  saturation occurred during this reduction (sticky)
- `busy`  output  1  high in ACCUM or DONE

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: `in_ready`=0, `out_valid`=0.
  - On `start`=1, latch `len`, clamped to VLEN if larger.
  - Clear accumulator, element counter and `out_sat`.
  - If latched len=0, go to DONE with `out_sum`=0. Otherwise go to ACCUM.
- ACCUM: `in_ready`=1.
  - A beat is accepted when `in_valid && in_ready`.
  - On each accepted beat: acc ← sat(acc + sext(`in_prod`)), counter++.
  - On the beat that makes counter = len, go to DONE.
  - No beat accepted: hold acc and counter.
- DONE: `out_valid`=1, `out_sum`=acc, `in_ready`=0.
  - On `out_valid && out_ready`, go to IDLE.
  - `out_sum`/`out_sat` hold their values until the next accepted `start`.
- Arithmetic:
  - The sum is computed at ACC_W+1 bits.
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to that maximum. If it is below -2^(ACC_W-1), clamp to that minimum.
  - Set `out_sat` on any clamp. `out_sat` stays set; subsequent beats still accumulate from the clamped value.
- `start` is ignored outside IDLE, including the DONE handshake cycle. `len` is ignored except when `start` is accepted.
- `in_prod` is ignored when no beat is accepted.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_sat`=0, `busy`=0, state IDLE. Reset applies immediately, asynchronously.
- `start` accepted at edge N: ACCUM from N+1, so `in_ready` is high in cycle N+1.
- Final beat accepted at edge M: DONE from M+1, so `out_valid` and the final `out_sum` are visible in cycle M+1.
  - Latency from the last beat to the result is 1 cycle.
  - `in_ready` drops in cycle M+1. There is no over-acceptance.
- Throughput: 1 beat/cycle with `in_valid` held high. A len=L reduction takes L+2 cycles from start to `out_valid`, with immediate `out_ready`.
- `out_valid` is held with a stable `out_sum` until the handshake. IDLE is reached the cycle after the handshake.
- Reset mid-ACCUM or mid-DONE discards the partial result. No `out_valid` is produced for the aborted reduction.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.

## Test plan
- Reset, then start len=4 with beats 3, -5, 10, 1 → `out_valid` one cycle after the 4th beat, `out_sum`=9, `out_sat`=0.
- Start len=8, eight beats of 127 (8'h7F) → `out_sum`=511 (10'h1FF), `out_sat`=1. Eight beats of -128 → `out_sum`=-512 (10'h200), `out_sat`=1.
- Start len=3 with `in_valid` toggling 1,0,1,0,1 (beats 2,7,-1, bubbles carrying junk 99) → `out_sum`=8. Bubbles ignored.
- Result held with `out_ready`=0 for 5 cycles → `out_valid` and `out_sum` stable. `start` pulses during DONE ignored. IDLE the cycle after `out_ready`=1.
- Start len=0 → DONE the next cycle, `out_sum`=0. Start len=12 with VLEN=8 → exactly 8 beats accepted, `in_ready` low afterward.
- Assert `rst` after 2 of 5 beats → all outputs 0 immediately. A new start len=1 with beat -7 → `out_sum`=-7.
